// File: rtl/footswitch_pkg.sv
// Shared types and constants for the footswitch conditioning block.
package footswitch_pkg;

  typedef enum logic [1:0] {
    FS_RELEASED,
    FS_PRESSED,
    FS_HELD
  } fs_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; btn_level only
// follows the synced input after DEBOUNCE_CYCLES consecutive differing samples.
module sync_debounce
  import footswitch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          deb_cnt;
  logic                   synced;

  // Flops reset to the raw level that means "not pressed".
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (synced == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_level <= synced;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/footswitch_pulse.sv
// Footswitch conditioner: debounced level plus single-cycle press / long-press
// command pulses. Long-press support is built only with FOOTSWITCH_LONG_PRESS_EN.
//
// state       | meaning
// FS_RELEASED | debounced level low, waiting for a press
// FS_PRESSED  | press accepted and pulsed, timing the hold
// FS_HELD     | long press already pulsed, waiting for release
module footswitch_pulse
  import footswitch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic long_press_pulse
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
    $error("footswitch_pulse: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  fs_state_t state_q, state_d;
  logic      press_d;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_sync_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_level(btn_level)
  );

`ifdef FOOTSWITCH_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES) + 1;

  logic [HW-1:0] hold_cnt;
  logic          long_d;

  // Cleared while released so it starts from zero on the press edge; saturates in HELD.
  always_ff @(posedge clk) begin
    if (rst)                                                    hold_cnt <= '0;
    else if (state_q == FS_RELEASED)                            hold_cnt <= '0;
    else if (state_q == FS_PRESSED && hold_cnt != HW'(LONG_CYCLES - 1)) hold_cnt <= hold_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) long_press_pulse <= 1'b0;
    else     long_press_pulse <= long_d;
  end
`else
  assign long_press_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_RELEASED;
      press_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_pulse <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    press_d = 1'b0;
`ifdef FOOTSWITCH_LONG_PRESS_EN
    long_d  = 1'b0;
`endif
    case (state_q)
      FS_RELEASED: begin
        if (btn_level) begin
          state_d = FS_PRESSED;
          press_d = 1'b1;
        end
      end
      FS_PRESSED: begin
        // Release is checked first so a fall on the terminal count suppresses the long pulse.
        if (!btn_level) begin
          state_d = FS_RELEASED;
        end
`ifdef FOOTSWITCH_LONG_PRESS_EN
        else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
          state_d = FS_HELD;
          long_d  = 1'b1;
        end
`endif
      end
`ifdef FOOTSWITCH_LONG_PRESS_EN
      FS_HELD: begin
        if (!btn_level) state_d = FS_RELEASED;
      end
`endif
      default: state_d = FS_RELEASED;
    endcase
  end

endmodule
